// File: rtl/mmc_cmd_phy.sv
// Host-side MMC command-line engine: divides clk into mmc_clk, sends a 48-bit
// CRC7-protected command frame and optionally captures a 48-bit response.
module mmc_cmd_phy #(
  parameter int CLK_DIV     = 4,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        rsp_expect,
  output logic        busy,
  output logic        done,
  output logic [5:0]  rsp_index,
  output logic [31:0] rsp_arg,
  output logic        rsp_crc_err,
  output logic        rsp_timeout,
  output logic        mmc_clk,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in
);

  typedef enum logic [2:0] {IDLE, TX, WAIT_RSP, RX, DONE} state_t;

  // Bit-serial CRC7 (x^7 + x^3 + 1, zero seed), MSB of data first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  logic [7:0]  div_cnt;
  logic        div_wrap;
  logic        rise_tick;
  logic        fall_tick;

  assign div_wrap  = (div_cnt == 8'(CLK_DIV - 1));
  assign rise_tick = div_wrap & ~mmc_clk;
  assign fall_tick = div_wrap & mmc_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      mmc_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      mmc_clk <= ~mmc_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  state_t      state;
  logic [47:0] tx_shift;
  logic [5:0]  bit_cnt;
  logic [9:0]  wait_cnt;
  logic [46:0] rx_shift;
  logic        rsp_expect_q;
  logic [39:0] new_head;
  logic [47:0] rx_word;
  logic        rx_bad;

  assign new_head = {2'b01, cmd_index, cmd_arg};
  // rx_word is the complete response as it stands on the 48th sampled bit.
  assign rx_word  = {rx_shift, cmd_in};
  assign rx_bad   = rx_word[46] | ~rx_word[0] | (rx_word[7:1] != crc7(rx_word[47:8]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tx_shift     <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      rx_shift     <= '0;
      rsp_expect_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rsp_index    <= '0;
      rsp_arg      <= '0;
      rsp_crc_err  <= 1'b0;
      rsp_timeout  <= 1'b0;
      cmd_out      <= 1'b1;
      cmd_oe       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_oe  <= 1'b0;
          cmd_out <= 1'b1;
          if (cmd_start) begin
            tx_shift     <= {new_head, crc7(new_head), 1'b1};
            rsp_expect_q <= rsp_expect;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            rsp_index    <= '0;
            rsp_arg      <= '0;
            rsp_crc_err  <= 1'b0;
            rsp_timeout  <= 1'b0;
            busy         <= 1'b1;
            state        <= TX;
          end
        end
        TX: begin
          if (fall_tick) begin
            // The 49th falling edge ends the end bit and hands the line back.
            if (bit_cnt == 6'd48) begin
              cmd_oe  <= 1'b0;
              cmd_out <= 1'b1;
              if (rsp_expect_q) begin
                state <= WAIT_RSP;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              cmd_oe   <= 1'b1;
              cmd_out  <= tx_shift[47];
              tx_shift <= {tx_shift[46:0], 1'b0};
              bit_cnt  <= bit_cnt + 6'd1;
            end
          end
        end
        WAIT_RSP: begin
          if (rise_tick) begin
            if (!cmd_in) begin
              rx_shift <= '0;
              bit_cnt  <= 6'd1;
              state    <= RX;
            end else if (wait_cnt == 10'(RSP_TIMEOUT - 1)) begin
              rsp_timeout <= 1'b1;
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 10'd1;
            end
          end
        end
        RX: begin
          if (rise_tick) begin
            rx_shift <= rx_word[46:0];
            if (bit_cnt == 6'd47) begin
              rsp_index   <= rx_word[45:40];
              rsp_arg     <= rx_word[39:8];
              rsp_crc_err <= rx_bad;
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_cmd_phy.sv
// Directed bench for mmc_cmd_phy: frame capture on the CMD line, a simple card
// model that answers after two mmc_clk periods, timeout, ignored starts, reset.
module tb_mmc_cmd_phy;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        rsp_expect = 1'b0;
  logic        cmd_in = 1'b1;
  logic        busy, done, rsp_crc_err, rsp_timeout, mmc_clk, cmd_out, cmd_oe;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;

  int vectors = 0;
  int miscompares = 0;

  mmc_cmd_phy #(.CLK_DIV(4), .RSP_TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .rsp_expect(rsp_expect), .busy(busy), .done(done),
    .rsp_index(rsp_index), .rsp_arg(rsp_arg), .rsp_crc_err(rsp_crc_err),
    .rsp_timeout(rsp_timeout), .mmc_clk(mmc_clk), .cmd_out(cmd_out),
    .cmd_oe(cmd_oe), .cmd_in(cmd_in)
  );

  always #5 clk = ~clk;

  // CRC7 by long division of {data, 7'b0} by 0x89.
  function automatic logic [6:0] ref_crc7(input logic [39:0] data);
    logic [46:0] r;
    r = {data, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  logic [47:0] tx_frame = '0;
  logic [47:0] card_frame = '0;
  bit          card_armed = 1'b0;
  bit          prev_mmc = 1'b0;
  bit          prev_oe = 1'b0;
  bit          counting = 1'b0;
  bit          rise_seen, fall_seen;
  int          tx_bits = 0, oe_cycles = 0, done_count = 0;
  int          rises_after_oe = 0, falls_after_oe = 0, done_rises = 0, card_idx = 0;
  int          base_done, base_bits, base_oe;

  // Line monitor and card model: frame bits are taken mid-bit on mmc_clk rise;
  // the card starts its reply on the second mmc_clk fall after the host lets go.
  always @(negedge clk) begin
    rise_seen = mmc_clk && !prev_mmc;
    fall_seen = !mmc_clk && prev_mmc;
    if (rise_seen && cmd_oe) begin
      tx_frame = {tx_frame[46:0], cmd_out};
      tx_bits++;
    end
    if (cmd_oe) oe_cycles++;
    if (prev_oe && !cmd_oe) begin
      counting       = 1'b1;
      rises_after_oe = 0;
      falls_after_oe = 0;
      card_idx       = 0;
      cmd_in         = 1'b1;
    end else if (counting) begin
      if (rise_seen) rises_after_oe++;
      if (fall_seen) begin
        falls_after_oe++;
        if (card_armed && falls_after_oe >= 2) begin
          if (card_idx < 48) begin
            cmd_in = card_frame[47 - card_idx];
            card_idx++;
          end else begin
            cmd_in = 1'b1;
          end
        end
      end
    end
    if (done) begin
      done_count++;
      done_rises = rises_after_oe;
      counting   = 1'b0;
    end
    prev_mmc = mmc_clk;
    prev_oe  = cmd_oe;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic expect_rsp);
    @(posedge clk);
    #1;
    base_done  = done_count;
    base_bits  = tx_bits;
    base_oe    = oe_cycles;
    cmd_index  = idx;
    cmd_arg    = arg;
    rsp_expect = expect_rsp;
    cmd_start  = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitForDone(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_done_wait"}, 64'd0, 64'd1);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cmd_oe", cmd_oe, 0);
    checkOutput("rst_cmd_out", cmd_out, 1);
    checkOutput("rst_mmc_clk", mmc_clk, 0);
    checkOutput("rst_rsp", {rsp_index, rsp_arg, rsp_crc_err, rsp_timeout}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // CMD0 without response
    applyStimulus(6'd0, 32'h0, 1'b0);
    checkOutput("t1_busy_after_accept", busy, 1);
    waitForDone("t1", 3000);
    checkOutput("t1_busy_in_done", busy, 0);
    settle();
    checkOutput("t1_frame", tx_frame, 48'h400000000095);
    checkOutput("t1_bits", tx_bits - base_bits, 48);
    checkOutput("t1_oe_cycles", oe_cycles - base_oe, 384);
    checkOutput("t1_timeout", rsp_timeout, 0);
    repeat (20) @(negedge clk);
    checkOutput("t1_done_count", done_count - base_done, 1);

    // CMD8 with a well-formed response
    card_frame = {2'b00, 6'd8, 32'h1AA, ref_crc7({2'b00, 6'd8, 32'h1AA}), 1'b1};
    card_armed = 1'b1;
    applyStimulus(6'd8, 32'h1AA, 1'b1);
    waitForDone("t2", 3000);
    settle();
    checkOutput("t2_frame", tx_frame, 48'h48000001AA87);
    checkOutput("t2_rsp_index", rsp_index, 8);
    checkOutput("t2_rsp_arg", rsp_arg, 32'h1AA);
    checkOutput("t2_crc_err", rsp_crc_err, 0);
    checkOutput("t2_timeout", rsp_timeout, 0);
    card_armed = 1'b0;
    repeat (20) @(negedge clk);

    // Card echoes the command frame: transmission bit is 1
    card_frame = 48'h48000001AA87;
    card_armed = 1'b1;
    applyStimulus(6'd8, 32'h1AA, 1'b1);
    checkOutput("t3_rsp_cleared", {rsp_index, rsp_arg}, 0);
    waitForDone("t3", 3000);
    settle();
    checkOutput("t3_crc_err", rsp_crc_err, 1);
    checkOutput("t3_rsp_index", rsp_index, 8);
    checkOutput("t3_rsp_arg", rsp_arg, 32'h1AA);
    card_armed = 1'b0;
    repeat (20) @(negedge clk);

    // No card: response timeout
    applyStimulus(6'd8, 32'h1AA, 1'b1);
    waitForDone("t4", 3000);
    settle();
    checkOutput("t4_timeout", rsp_timeout, 1);
    checkOutput("t4_crc_err", rsp_crc_err, 0);
    checkOutput("t4_done_rises", done_rises, 64);
    repeat (20) @(negedge clk);

    // cmd_start during TX and during the DONE cycle are ignored
    applyStimulus(6'd0, 32'h0, 1'b0);
    for (int i = 0; i < 2000 && (tx_bits - base_bits) < 10; i++) @(posedge clk);
    #1;
    cmd_index  = 6'd8;
    cmd_arg    = 32'h1AA;
    rsp_expect = 1'b1;
    cmd_start  = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    waitForDone("t5", 3000);
    cmd_start = 1'b1;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("t5_frame", tx_frame, 48'h400000000095);
    checkOutput("t5_bits", tx_bits - base_bits, 48);
    checkOutput("t5_done_count", done_count - base_done, 1);
    checkOutput("t5_busy_idle", busy, 0);
    checkOutput("t5_timeout", rsp_timeout, 0);

    // Reset in the middle of the frame
    applyStimulus(6'd0, 32'h0, 1'b0);
    for (int i = 0; i < 2000 && (tx_bits - base_bits) < 20; i++) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_oe_async", cmd_oe, 0);
    checkOutput("t6_out_async", cmd_out, 1);
    checkOutput("t6_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(6'd0, 32'h0, 1'b0);
    waitForDone("t6", 3000);
    settle();
    checkOutput("t6_frame", tx_frame, 48'h400000000095);
    checkOutput("t6_bits", tx_bits - base_bits, 48);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmc_cmd_phy.md
Name: mmc_cmd_phy

Overview:
- Host-side MMC command-line engine for the CPLD; sits behind the MMC pad buffer block.
- Generates the MMC clock and serialises a 48-bit command frame with CRC7 onto the CMD line.
- Optionally captures the card's 48-bit response, checks framing and CRC7, and reports it.
- 136-bit (R2) responses and the data lines are out of scope.

Parameters:
- CLK_DIV, 4: half-period of mmc_clk in clk cycles (mmc_clk = clk/(2*CLK_DIV)); legal range is 1 to 255.
- RSP_TIMEOUT, 64: number of mmc_clk rising edges to wait for a response start bit; legal range is 2 to 1023.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_start  input  1  one-cycle request to send a command; accepted only in IDLE
- cmd_index  input  6  command index, latched on accept
- cmd_arg  input  32  command argument, latched on accept
- rsp_expect  input  1  1 = capture a 48-bit response after the command; latched on accept
- busy  output  1  high from the cycle after accept until the DONE cycle (exclusive)
- done  output  1  one-cycle completion pulse
- rsp_index  output  6  received response bits [45:40]
- rsp_arg  output  32  received response bits [39:8]
- rsp_crc_err  output  1  response CRC, transmission bit or end bit was bad
- rsp_timeout  output  1  no response start bit within RSP_TIMEOUT
- mmc_clk  output  1  MMC clock to the pad
- cmd_out  output  1  value driven on the CMD pad
- cmd_oe  output  1  CMD pad output enable
- cmd_in  input  1  value sampled from the CMD pad

Behaviour:
- Reset values: all outputs 0, except cmd_out=1. Reset clears all state and returns to IDLE. Asserting reset mid-frame releases cmd_oe immediately (asynchronously).
- Clock divider:
  - A counter runs 0..CLK_DIV-1; when it wraps, mmc_clk toggles.
  - A 0->1 toggle produces rise_tick; a 1->0 toggle produces fall_tick (each one clk wide).
  - mmc_clk free-runs from reset.
- Frame format, sent MSB first: {1'b0, 1'b1, index[5:0], arg[31:0], crc7[6:0], 1'b1}.
  - CRC7 polynomial is x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - Known values: CMD0 arg 0 gives frame 0x400000000095; CMD8 arg 0x1AA gives 0x48000001AA87.
- State IDLE:
  - cmd_oe=0, cmd_out=1.
  - cmd_start latches inputs, clears rsp_* outputs and moves to TX. busy rises on the next cycle.
- State TX:
  - On each fall_tick, drive the next frame bit with cmd_oe=1; each bit is held one full mmc_clk period.
  - On the 49th fall_tick, set cmd_oe=0 and cmd_out=1.
  - If rsp_expect=1, go to WAIT_RSP; otherwise go to DONE.
- State WAIT_RSP:
  - Sample cmd_in on each rise_tick.
  - A sampled 0 is the start bit: go to RX with bit count 1.
  - After RSP_TIMEOUT rise_ticks with no start bit: set rsp_timeout=1 and go to DONE.
- State RX:
  - Shift in 47 more bits on rise_ticks.
  - After the 48th bit:
    - Load rsp_index and rsp_arg.
    - Set rsp_crc_err=1 if any of these hold: bit46≠0, bit0≠1, or bits[7:1] ≠ CRC7 of bits[47:8].
  - Go to DONE.
- State DONE: done=1 and busy=0 for exactly one clk cycle, then IDLE.
- cmd_start in any state other than IDLE (including DONE) is ignored; no queuing.
- rsp_* outputs hold their value until the next accepted cmd_start.
- cmd_oe is never 1 outside TX.

Test Plan:
- CMD0, arg 0, rsp_expect=0, CLK_DIV=4 -> cmd_out bits on successive fall edges = 0x400000000095; cmd_oe high for exactly 48 mmc_clk periods; done pulses once; rsp_timeout=0.
- CMD8, arg 0x1AA, rsp_expect=1; bench card model replies 2 mmc_clk periods after the end bit with frame {0,0,6'd8,32'h1AA,CRC7 from bench model,1} -> rsp_index=8, rsp_arg=0x1AA, rsp_crc_err=0.
- Same exchange, but the card echoes 0x48000001AA87 (transmission bit=1) -> rsp_crc_err=1, rsp_index=8.
- rsp_expect=1 with cmd_in held at 1, RSP_TIMEOUT=64 -> rsp_timeout=1; done occurs 64 rise_ticks after cmd_oe falls.
- cmd_start pulsed during TX and during the DONE cycle -> both ignored; frame unchanged; exactly one done.
- reset_n asserted mid-TX (bit 20) -> cmd_oe=0, cmd_out=1, busy=0 immediately; a new CMD0 after release transmits correctly.
